// File: rtl/debounce_encoder_pkg.sv
// Shared constants for the debounce_encoder block.
//   TRIG_*  : trigger codes presented to the downstream monostable
//   state_t : encoder FSM states
//   first_code() : lowest-index pressed button -> trigger code
//   held_level() : stable level of the button that a trigger code refers to
package debounce_encoder_pkg;

    localparam logic [1:0] TRIG_NONE = 2'd0;
    localparam logic [1:0] TRIG_B0   = 2'd1;
    localparam logic [1:0] TRIG_B1   = 2'd2;
    localparam logic [1:0] TRIG_B2   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Lowest index wins when several buttons are stable-pressed together.
    function automatic logic [1:0] first_code(input logic [2:0] lvl);
        logic [1:0] code;
        code = TRIG_NONE;
        if (lvl[0])      code = TRIG_B0;
        else if (lvl[1]) code = TRIG_B1;
        else if (lvl[2]) code = TRIG_B2;
        return code;
    endfunction

    function automatic logic held_level(input logic [2:0] lvl, input logic [1:0] code);
        logic bit_lvl;
        bit_lvl = 1'b0;
        case (code)
            TRIG_B0: bit_lvl = lvl[0];
            TRIG_B1: bit_lvl = lvl[1];
            TRIG_B2: bit_lvl = lvl[2];
            default: bit_lvl = 1'b0;
        endcase
        return bit_lvl;
    endfunction

endpackage

// File: rtl/debounce_encoder_if.sv
// Button/trigger bundle between the button source and debounce_encoder.
//   botones : raw button levels (1 = pressed), asynchronous to the clock
//   trigger : registered trigger code, 0 = none, 1..3 = button 0..2
//   state   : encoder FSM state, exposed for observation
// No handshake: botones is a free-running level input, trigger a level output.
interface debounce_encoder_if;
    import debounce_encoder_pkg::*;

    logic [2:0] botones;
    logic [1:0] trigger;
    state_t     state;

    modport master (output botones, input trigger, input state);
    modport slave  (input botones, output trigger, output state);
endinterface

// File: rtl/debounce_encoder_debounce_bit.sv
// debounce_bit: one button channel.
//   reloj  : clock
//   resetM : asynchronous active-high reset
//   raw    : raw asynchronous button level
//   stable : debounced level
// A 2-FF synchronizer feeds a counter that must see DEBOUNCE_CYCLES
// consecutive samples differing from the current stable level before the
// stable level follows. Press and release are treated identically.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic reloj,
    input  logic resetM,
    input  logic raw,
    output logic stable
);
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync != stable) begin
                // Accept on the DEBOUNCE_CYCLES-th differing sample; the
                // counter is cleared here so it never passes CNT_LAST.
                if (cnt == CNT_LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/debounce_encoder.sv
// debounce_encoder: three raw buttons -> clean 2-bit trigger code.
//   reloj  : clock
//   resetM : asynchronous active-high reset (trigger drops to 0 at once)
//   bus    : debounce_encoder_if.slave (botones in, trigger/state out)
// Each button is debounced by a debounce_bit instance. The FSM latches the
// lowest-index stable button into trigger and holds it, ignoring others,
// until that button's stable level falls; it then returns to IDLE with
// trigger = 0 for at least one cycle before any new code is taken.
module debounce_encoder
    import debounce_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              reloj,
    input  logic              resetM,
    debounce_encoder_if.slave bus
);
    logic [2:0] stable;
    logic [1:0] trigger_q;
    state_t     state_q;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .reloj  (reloj),
            .resetM (resetM),
            .raw    (bus.botones[i]),
            .stable (stable[i])
        );
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state_q   <= ST_IDLE;
            trigger_q <= TRIG_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stable != 3'b000) begin
                        state_q   <= ST_HOLD;
                        trigger_q <= first_code(stable);
                    end
                end
                ST_HOLD: begin
                    // The held code identifies which button to watch.
                    if (!held_level(stable, trigger_q)) begin
                        state_q   <= ST_IDLE;
                        trigger_q <= TRIG_NONE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    trigger_q <= TRIG_NONE;
                end
            endcase
        end
    end

    assign bus.trigger = trigger_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_debounce_encoder.sv
module tb_debounce_encoder;
    import debounce_encoder_pkg::*;

    localparam int D = 4;

    logic reloj;
    logic resetM;
    debounce_encoder_if bus ();

    debounce_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic running = 1'b1;

    // clock / reset
    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    // ---------------- behavioural model ----------------
    // samp[0] is the raw value sampled at the latest edge, samp[k] k edges
    // earlier. A level becomes stable once D consecutive synchronized samples
    // (raw delayed by two edges) all disagree with the current stable level.
    logic [2:0] samp [$];
    logic [2:0] m_stable;
    logic [1:0] m_trig;

    task automatic m_clear();
        samp.delete();
        for (int k = 0; k < D + 2; k++) samp.push_back(3'b000);
        m_stable = 3'b000;
        m_trig   = 2'd0;
    endtask

    task automatic m_step(input logic [2:0] raw_now);
        logic all_diff;
        // encoder acts on stable levels as they were before this edge
        if (m_trig == 2'd0) begin
            if (m_stable[0])      m_trig = 2'd1;
            else if (m_stable[1]) m_trig = 2'd2;
            else if (m_stable[2]) m_trig = 2'd3;
        end else if (!m_stable[int'(m_trig) - 1]) begin
            m_trig = 2'd0;
        end
        samp.push_front(raw_now);
        void'(samp.pop_back());
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (samp[2 + j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) m_stable[b] = ~m_stable[b];
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge reloj or posedge resetM);
            if (resetM) m_clear();
            else        m_step(bus.botones);
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    logic [1:0] prev_trig = 2'd0;
    initial begin
        forever begin
            @(negedge reloj);
            if (running && !resetM) begin
                n_cmp++;
                if (bus.trigger !== m_trig) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t trigger=%0d expected=%0d", $time, bus.trigger, m_trig);
                end
                n_cmp++;
                if (prev_trig != 2'd0 && bus.trigger != 2'd0 && bus.trigger !== prev_trig) begin
                    n_fail++;
                    $display("FAIL no_direct_change t=%0t trigger=%0d previous=%0d", $time, bus.trigger, prev_trig);
                end
            end
            prev_trig = resetM ? 2'd0 : bus.trigger;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(negedge reloj);
    endtask

    task automatic check_lit(input string name, input logic [1:0] exp);
        n_cmp++;
        if (bus.trigger !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t trigger=%0d expected=%0d", name, $time, bus.trigger, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v);
        bus.botones = v;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        resetM = 1'b1;
        bus.botones = 3'b000;
        wait_edges(3);
        check_lit("reset_value", 2'd0);
        resetM = 1'b0;
        wait_edges(2);

        // clean press / release: code appears on the 7th edge
        drive(3'b001);
        wait_edges(6); check_lit("press_b0_edge6", 2'd0);
        wait_edges(1); check_lit("press_b0_edge7", 2'd1);
        drive(3'b000);
        wait_edges(6); check_lit("release_b0_edge6", 2'd1);
        wait_edges(1); check_lit("release_b0_edge7", 2'd0);
        wait_edges(4);

        // bounce on bit1, then held
        drive(3'b010); wait_edges(2);
        drive(3'b000); wait_edges(2);
        check_lit("bounce_no_trigger", 2'd0);
        drive(3'b010);
        wait_edges(6); check_lit("bounce_b1_edge6", 2'd0);
        wait_edges(1); check_lit("bounce_b1_edge7", 2'd2);
        drive(3'b000); wait_edges(10);
        check_lit("bounce_released", 2'd0);

        // priority: bit1 beats bit2, then 1-cycle gap to bit2
        drive(3'b110);
        wait_edges(7); check_lit("prio_b1", 2'd2);
        drive(3'b100);
        wait_edges(6); check_lit("prio_hold_b1", 2'd2);
        wait_edges(1); check_lit("prio_gap", 2'd0);
        wait_edges(1); check_lit("prio_b2", 2'd3);
        drive(3'b000); wait_edges(10);

        // hold lockout
        drive(3'b001);
        wait_edges(7); check_lit("lock_b0", 2'd1);
        drive(3'b101);
        wait_edges(8); check_lit("lock_ignores_b2", 2'd1);
        drive(3'b100);
        wait_edges(7); check_lit("lock_gap", 2'd0);
        wait_edges(1); check_lit("lock_b2", 2'd3);

        // async reset mid-hold, bit2 still pressed
        wait_edges(2);
        #2 resetM = 1'b1;
        #1 check_lit("async_reset", 2'd0);
        wait_edges(2);
        resetM = 1'b0;
        wait_edges(6); check_lit("after_reset_edge6", 2'd0);
        wait_edges(1); check_lit("after_reset_edge7", 2'd3);
        drive(3'b000); wait_edges(10);

        // short glitch on bit0 (3 cycles)
        drive(3'b001); wait_edges(3);
        drive(3'b000);
        for (int i = 0; i < 10; i++) begin
            wait_edges(1);
            check_lit("glitch_no_trigger", 2'd0);
        end

        running = 1'b0;
        wait_edges(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
